mining_job_scheduler: RTL

//   Sequences one SHA-256d hash core from UART-delivered block headers. Latches the 640-bit

---
 rtl/mining_pkg.sv | 20 ++
 rtl/nonce_stepper.sv | 38 +++
 rtl/mining_job_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mining_pkg.sv
// Shared types and widths for the mining job scheduler.
// Header layout: nonce field occupies word [31:0].
package mining_pkg;

  localparam int HEADER_W      = 640;
  localparam int NONCE_W       = 32;
  localparam int HDR_NONCE_LSB = 0;
  localparam int HOLD_W        = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_STEP   = 3'd4,
    S_REPORT = 3'd5,
    S_TXWAIT = 3'd6
  } state_t;

endpackage

// File: rtl/nonce_stepper.sv
// Holds the current nonce and the sticky exhausted flag.
// Steps by NONCE_STEP with no wrap past NONCE_END.
module nonce_stepper
  import mining_pkg::*;
#(
  parameter logic [NONCE_W-1:0] NONCE_START = '0,
  parameter logic [NONCE_W-1:0] NONCE_END   = '1,
  parameter logic [NONCE_W-1:0] NONCE_STEP  = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  output logic [NONCE_W-1:0] nonce,
  output logic               exhausted,
  output logic               over
);

  logic [NONCE_W:0] sum;

  // Carry bit counts as overflow, so the range never wraps.
  assign sum  = {1'b0, nonce} + {1'b0, NONCE_STEP};
  assign over = sum > {1'b0, NONCE_END};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nonce     <= '0;
      exhausted <= 1'b0;
    end else if (load) begin
      nonce     <= NONCE_START;
      exhausted <= 1'b0;
    end else if (step) begin
      if (over) exhausted <= 1'b1;
      else      nonce     <= sum[NONCE_W-1:0];
    end
  end

endmodule

// File: rtl/mining_job_scheduler.sv
// Feeds one SHA-256d core from UART headers, sweeping the nonce range
// and handing hits to the UART transmitter.
module mining_job_scheduler
  import mining_pkg::*;
#(
  parameter logic [NONCE_W-1:0] NONCE_START     = 32'h0000_0000,
  parameter logic [NONCE_W-1:0] NONCE_END       = 32'hFFFF_FFFF,
  parameter logic [NONCE_W-1:0] NONCE_STEP      = 32'd1,
  parameter int unsigned        TX_HOLD         = 4,
  parameter bit                 CONTINUE_ON_HIT = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [HEADER_W-1:0] hdr_data,
  input  logic                hdr_valid,
  output logic [HEADER_W-1:0] core_header,
  output logic [NONCE_W-1:0]  core_nonce,
  output logic                core_start,
  output logic                core_abort,
  input  logic                core_done,
  input  logic                core_hit,
  output logic [NONCE_W-1:0]  tx_nonce,
  output logic                tx_start,
  input  logic                tx_busy,
  output logic                exhausted,
  output logic [15:0]         found_count,
  output logic [2:0]          state_dbg
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TX_HOLD - 1);

  state_t state, state_n;

  logic [HEADER_W-1:NONCE_W] hdr_q;
  logic [HEADER_W-1:NONCE_W] shadow_q;
  logic                      pending;
  logic [HOLD_W-1:0]         hold_cnt;
  logic                      load_hdr;
  logic                      use_shadow;
  logic                      step;
  logic                      over;
  logic                      hit_take;
  logic                      in_report;
  logic                      unused_nonce_bits;

  // The incoming nonce word is always replaced by the swept nonce.
  assign unused_nonce_bits = ^hdr_data[NONCE_W-1:HDR_NONCE_LSB];

  assign core_header = {hdr_q, core_nonce};
  assign state_dbg   = state;
  assign in_report   = (state == S_REPORT) || (state == S_TXWAIT);
  assign load_hdr    = (state_n == S_LOAD) && (state != S_LOAD);
  assign use_shadow  = pending && !hdr_valid;
  assign hit_take    = (state == S_WAIT) && !hdr_valid &&
                       core_done && core_hit;

  nonce_stepper #(
    .NONCE_START (NONCE_START),
    .NONCE_END   (NONCE_END),
    .NONCE_STEP  (NONCE_STEP)
  ) u_stepper (
    .clock     (clock),
    .reset     (reset),
    .load      (load_hdr),
    .step      (step),
    .nonce     (core_nonce),
    .exhausted (exhausted),
    .over      (over)
  );

  always_comb begin
    state_n    = state;
    core_start = 1'b0;
    core_abort = 1'b0;
    tx_start   = 1'b0;
    step       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (hdr_valid) state_n = S_LOAD;
      end
      S_LOAD: begin
        state_n = S_START;
      end
      S_START: begin
        if (hdr_valid) begin
          core_abort = 1'b1;
          state_n    = S_LOAD;
        end else begin
          core_start = 1'b1;
          state_n    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (hdr_valid) begin
          core_abort = 1'b1;
          state_n    = S_LOAD;
        end else if (core_done) begin
          state_n = core_hit ? S_REPORT : S_STEP;
        end
      end
      S_STEP: begin
        if (hdr_valid) begin
          core_abort = 1'b1;
          state_n    = S_LOAD;
        end else begin
          step    = 1'b1;
          state_n = over ? S_IDLE : S_START;
        end
      end
      S_REPORT: begin
        // Once the hold has begun it runs to completion.
        if (hold_cnt != '0 || !tx_busy) begin
          tx_start = 1'b1;
          if (hold_cnt == HOLD_LAST) state_n = S_TXWAIT;
        end
      end
      S_TXWAIT: begin
        if (!tx_busy) begin
          if (pending || hdr_valid) state_n = S_LOAD;
          else if (CONTINUE_ON_HIT) state_n = S_STEP;
          else                      state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      hdr_q       <= '0;
      shadow_q    <= '0;
      pending     <= 1'b0;
      hold_cnt    <= '0;
      tx_nonce    <= '0;
      found_count <= '0;
    end else begin
      state <= state_n;
      if (load_hdr) begin
        hdr_q   <= use_shadow ? shadow_q : hdr_data[HEADER_W-1:NONCE_W];
        pending <= 1'b0;
      end else if (hdr_valid && in_report) begin
        shadow_q <= hdr_data[HEADER_W-1:NONCE_W];
        pending  <= 1'b1;
      end
      if (tx_start) begin
        hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + 1'b1;
      end
      if (hit_take) begin
        tx_nonce <= core_nonce;
        if (found_count != 16'hFFFF) found_count <= found_count + 16'd1;
      end
    end
  end

endmodule
